lifo_stack_ctrl: RTL and testbench

//  Parametrised hardware LIFO for the MCU call/interrupt return path; generalises the 16x16 stack.

---
 rtl/stack_pkg.sv | 23 ++
 rtl/stack_regfile.sv | 29 ++
 rtl/lifo_stack_ctrl.sv | 179 +++++++++++++++++
 tb/tb_lifo_stack_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared encodings for the LIFO stack controller: command opcodes, FSM states and the
// occupancy-count width helper.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Count must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x DATA_W stack storage: one synchronous write port, two asynchronous read ports.
// Contents are intentionally not reset.
module stack_regfile #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/lifo_stack_ctrl.sv
// Parametrised LIFO controller for the call/interrupt return path: NOP/PUSH/POP/REPLACE with
// sticky error flags. Define STACK_HIGH_WATER_EN to add the hwm (high-water mark) output.
module lifo_stack_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              ovf_err,
  output logic              unf_err,
  input  logic              err_clr
`ifdef STACK_HIGH_WATER_EN
  , output logic [CNT_W-1:0] hwm
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [CNT_W-1:0]  sp_q, sp_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              accept, we;
  logic [AW-1:0]     waddr, top_addr;
  logic [DATA_W-1:0] top_data, pop_data;

  assign accept   = cs && ready;
  assign top_addr = AW'(sp_q - CNT_W'(1));

  stack_regfile #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk    (clk),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata_q),
    .raddr_a(top_addr),
    .rdata_a(top_data),
    .raddr_b(top_addr),
    .rdata_b(pop_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cs) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == ST_IDLE);
    done  = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= OP_NOP;
      wdata_q <= '0;
    end else if (accept) begin
      op_q    <= op_e'(op);
      wdata_q <= wr_data;
    end
  end

  // Errors set after the clear so a same-cycle new error wins.
  always_comb begin
    sp_d      = sp_q;
    rd_data_d = rd_data_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    we        = 1'b0;
    waddr     = top_addr;
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (state_q == ST_EXEC) begin
      unique case (op_q)
        OP_PUSH: begin
          if (!full) begin
            we    = 1'b1;
            waddr = AW'(sp_q);
            sp_d  = sp_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        OP_POP: begin
          if (!empty) begin
            rd_data_d = pop_data;
            sp_d      = sp_q - CNT_W'(1);
          end else begin
            unf_d = 1'b1;
          end
        end
        OP_REPLACE: begin
          if (!empty) begin
            we = 1'b1;
          end else begin
            unf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q      <= '0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      sp_q      <= sp_d;
      rd_data_q <= rd_data_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign rd_data = rd_data_q;
  assign count   = sp_q;
  assign empty   = (sp_q == '0);
  assign full    = (sp_q == CNT_W'(DEPTH));
  assign top     = empty ? '0 : top_data;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

`ifdef STACK_HIGH_WATER_EN
  logic [CNT_W-1:0] hwm_q, hwm_d;

  // Only growth raises the mark, so a clear while occupied reads back as zero.
  always_comb begin
    hwm_d = err_clr ? '0 : hwm_q;
    if (sp_d > sp_q && sp_d > hwm_d) begin
      hwm_d = sp_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_lifo_stack_ctrl.sv
// Scoreboard bench for lifo_stack_ctrl: directed scenarios plus random ops against a
// queue-based stack model. Define STACK_HIGH_WATER_EN to also check hwm.
module tb_lifo_stack_ctrl;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  localparam logic [1:0] P_NOP = 2'b00;
  localparam logic [1:0] P_PUSH = 2'b01;
  localparam logic [1:0] P_POP = 2'b10;
  localparam logic [1:0] P_REPL = 2'b11;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cs = 1'b0;
  logic              err_clr = 1'b0;
  logic [1:0]        op = 2'b00;
  logic [DATA_W-1:0] wr_data = '0;
  logic              ready, done, empty, full, ovf_err, unf_err;
  logic [DATA_W-1:0] rd_data, top;
  logic [CNT_W-1:0]  count;
`ifdef STACK_HIGH_WATER_EN
  logic [CNT_W-1:0]  hwm;
`endif

  lifo_stack_ctrl #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .cs     (cs),
    .op     (op),
    .wr_data(wr_data),
    .ready  (ready),
    .done   (done),
    .rd_data(rd_data),
    .top    (top),
    .count  (count),
    .empty  (empty),
    .full   (full),
    .ovf_err(ovf_err),
    .unf_err(unf_err),
    .err_clr(err_clr)
`ifdef STACK_HIGH_WATER_EN
    , .hwm  (hwm)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int rd;
    int cnt;
    int tp;
    int ovf;
    int unf;
    int hw;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   m_stack[$];
  int   m_rd, m_ovf, m_unf, m_hwm;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no pending request (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle", 32'(cyc), 32'(mon_e.due));
        check("rd_data", 32'(rd_data), 32'(mon_e.rd));
        check("count", 32'(count), 32'(mon_e.cnt));
        check("top", 32'(top), 32'(mon_e.tp));
        check("empty", 32'(empty), 32'(mon_e.cnt == 0));
        check("full", 32'(full), 32'(mon_e.cnt == int'(DEPTH)));
        check("ovf_err", 32'(ovf_err), 32'(mon_e.ovf));
        check("unf_err", 32'(unf_err), 32'(mon_e.unf));
`ifdef STACK_HIGH_WATER_EN
        check("hwm", 32'(hwm), 32'(mon_e.hw));
`endif
      end
    end
  end

  // Called at a negedge while idle; holds cs and scrambles op/wr_data after accept.
  task automatic issue(input logic [1:0] o, input logic [DATA_W-1:0] d);
    exp_t e;
    check("ready_at_issue", 32'(ready), 32'd1);
    cs      = 1'b1;
    op      = o;
    wr_data = d;
    if (o == P_PUSH) begin
      if (m_stack.size() < int'(DEPTH)) begin
        m_stack.push_back(int'(d));
        if (m_stack.size() > m_hwm) m_hwm = m_stack.size();
      end else begin
        m_ovf = 1;
      end
    end else if (o == P_POP) begin
      if (m_stack.size() > 0) m_rd = m_stack.pop_back();
      else m_unf = 1;
    end else if (o == P_REPL) begin
      if (m_stack.size() > 0) m_stack[m_stack.size()-1] = int'(d);
      else m_unf = 1;
    end
    e.rd  = m_rd;
    e.cnt = m_stack.size();
    e.tp  = (m_stack.size() > 0) ? m_stack[m_stack.size()-1] : 0;
    e.ovf = m_ovf;
    e.unf = m_unf;
    e.hw  = m_hwm;
    e.due = cyc + 2;
    sb.push_back(e);
    @(negedge clk);
    op      = 2'($urandom);
    wr_data = DATA_W'($urandom);
    @(negedge clk);
    op      = 2'($urandom);
    wr_data = DATA_W'($urandom);
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ovf = 0;
    m_unf = 0;
    m_hwm = 0;
    check("ovf_after_clr", 32'(ovf_err), 32'd0);
    check("unf_after_clr", 32'(unf_err), 32'd0);
`ifdef STACK_HIGH_WATER_EN
    check("hwm_after_clr", 32'(hwm), 32'd0);
`endif
  endtask

  task automatic model_reset();
    m_stack.delete();
    m_rd  = 0;
    m_ovf = 0;
    m_unf = 0;
    m_hwm = 0;
  endtask

  task automatic check_idle_reset_state(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_top"}, 32'(top), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_ovf"}, 32'(ovf_err), 32'd0);
    check({tag, "_unf"}, 32'(unf_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    model_reset();
    #2 reset = 1'b0;
    #1;
    check_idle_reset_state("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Basic push/push/pop
    issue(P_PUSH, 16'h1234);
    issue(P_PUSH, 16'hABCD);
    check("top_after_push", 32'(top), 32'h0000ABCD);
    check("count_after_push", 32'(count), 32'd2);
    issue(P_POP, 16'h0000);
    check("rd_after_pop", 32'(rd_data), 32'h0000ABCD);
    issue(P_POP, 16'h0000);

    // Fill, overflow, then drain to verify contents survived
    for (int i = 0; i < int'(DEPTH); i++) issue(P_PUSH, DATA_W'(16'h0100 + i));
    issue(P_PUSH, 16'hBEEF);
    check("full_after_ovf", 32'(full), 32'd1);
    check("ovf_flag", 32'(ovf_err), 32'd1);
    for (int i = 0; i < int'(DEPTH); i++) issue(P_POP, 16'h0000);

    // Underflow on empty, then clear
    issue(P_POP, 16'h0000);
    check("unf_flag", 32'(unf_err), 32'd1);
    check("rd_kept_on_unf", 32'(rd_data), 32'h00000100);
    issue(P_REPL, 16'h5555);
    clr();

    // Replace top
    issue(P_PUSH, 16'h0001);
    issue(P_REPL, 16'h00FF);
    check("top_after_repl", 32'(top), 32'h000000FF);
    issue(P_POP, 16'h0000);
    check("empty_after_repl_pop", 32'(empty), 32'd1);
    issue(P_NOP, 16'h7777);

    // High-water tracking: push 5, pop 3, clear
    clr();
    for (int i = 0; i < 5; i++) issue(P_PUSH, DATA_W'(16'h0A00 + i));
    for (int i = 0; i < 3; i++) issue(P_POP, 16'h0000);
`ifdef STACK_HIGH_WATER_EN
    check("hwm_5", 32'(hwm), 32'd5);
`endif
    check("count_2", 32'(count), 32'd2);
    clr();

    // Reset asserted while a push is in EXEC; cs stays high throughout
    cs      = 1'b1;
    op      = P_PUSH;
    wr_data = 16'hDEAD;
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check_idle_reset_state("midreset");
    @(negedge clk);
    reset = 1'b1;
    cs    = 1'b0;
    repeat (4) @(negedge clk);
    check("midreset_count_after", 32'(count), 32'd0);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45) issue(P_PUSH, DATA_W'($urandom));
      else if (r < 75) issue(P_POP, DATA_W'($urandom));
      else if (r < 85) issue(P_REPL, DATA_W'($urandom));
      else if (r < 93) issue(P_NOP, DATA_W'($urandom));
      else clr();
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
